// File: rtl/gpr_writeback_arb.sv
// Round-robin writeback arbiter: filters non-writing commits and issues one registered GPR write per cycle.
// One-cycle latency from acceptance to wb_*. When the output stalls, writing sources see req_ready low and wb_* hold.
module gpr_writeback_arb #(
  parameter int NUM_REQS    = 4,
  parameter int NUM_THREADS = 4,
  parameter int NUM_WARPS   = 4,
  parameter int NUM_REGS    = 64,
  parameter int DATAW       = 32,
  localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int RD_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int PTR_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  localparam int LANEW = NUM_THREADS * DATAW
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQS-1:0]             req_valid,
  input  logic [NUM_REQS-1:0]             req_wb,
  input  logic [NUM_REQS*WID_W-1:0]       req_wid,
  input  logic [NUM_REQS*RD_W-1:0]        req_rd,
  input  logic [NUM_REQS*NUM_THREADS-1:0] req_tmask,
  input  logic [NUM_REQS*LANEW-1:0]       req_data,
  output logic [NUM_REQS-1:0]             req_ready,
  output logic                            wb_valid,
  output logic [WID_W-1:0]                wb_wid,
  output logic [RD_W-1:0]                 wb_rd,
  output logic [NUM_THREADS-1:0]          wb_tmask,
  output logic [LANEW-1:0]                wb_data,
  input  logic                            wb_ready,
  output logic [31:0]                     perf_conflicts
);

  function automatic logic [PTR_W-1:0] wrap_idx(input int base, input int ofs);
    return PTR_W'((base + ofs) % NUM_REQS);
  endfunction

  logic [NUM_REQS-1:0] writing;
  logic [NUM_REQS-1:0] grant_vec;
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    grant_idx;
  logic                grant_found;
  logic                can_load;
  logic                grant;

  // A commit only reaches the register file if it names a real register and some thread writes it.
  always_comb begin
    writing = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      writing[i] = req_valid[i] & req_wb[i]
                 & (|req_rd[i*RD_W +: RD_W])
                 & (|req_tmask[i*NUM_THREADS +: NUM_THREADS]);
    end
  end

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      if (!grant_found && writing[wrap_idx(int'(rr_ptr), k)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_idx(int'(rr_ptr), k);
      end
    end
  end

  assign can_load = ~wb_valid | wb_ready;
  assign grant    = grant_found & can_load & ~reset;

  always_comb begin
    grant_vec            = '0;
    grant_vec[grant_idx] = grant;
  end

  // Non-writing commits are retired immediately regardless of output stall.
  assign req_ready = reset ? '0 : ((req_valid & ~writing) | grant_vec);

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid       <= 1'b0;
      wb_wid         <= '0;
      wb_rd          <= '0;
      wb_tmask       <= '0;
      wb_data        <= '0;
      rr_ptr         <= '0;
      perf_conflicts <= '0;
    end else begin
      if ($countones(writing) > 1) begin
        perf_conflicts <= perf_conflicts + 32'd1;
      end
      if (grant) begin
        wb_valid <= 1'b1;
        wb_wid   <= req_wid[grant_idx*WID_W +: WID_W];
        wb_rd    <= req_rd[grant_idx*RD_W +: RD_W];
        wb_tmask <= req_tmask[grant_idx*NUM_THREADS +: NUM_THREADS];
        wb_data  <= req_data[grant_idx*LANEW +: LANEW];
        rr_ptr   <= wrap_idx(int'(grant_idx), 1);
      end else if (wb_ready) begin
        wb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gpr_writeback_arb.sv
// Randomized and directed bench for gpr_writeback_arb against a transaction-level reference model.
module tb_gpr_writeback_arb;
  localparam int NR   = 4;
  localparam int NT   = 4;
  localparam int WIDW = 2;
  localparam int RDW  = 6;
  localparam int LW   = NT * 32;

  logic                 clk;
  logic                 reset;
  logic [NR-1:0]        req_valid;
  logic [NR-1:0]        req_wb;
  logic [NR*WIDW-1:0]   req_wid;
  logic [NR*RDW-1:0]    req_rd;
  logic [NR*NT-1:0]     req_tmask;
  logic [NR*LW-1:0]     req_data;
  logic [NR-1:0]        req_ready;
  logic                 wb_valid;
  logic [WIDW-1:0]      wb_wid;
  logic [RDW-1:0]       wb_rd;
  logic [NT-1:0]        wb_tmask;
  logic [LW-1:0]        wb_data;
  logic                 wb_ready;
  logic [31:0]          perf_conflicts;

  gpr_writeback_arb dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_wb(req_wb), .req_wid(req_wid), .req_rd(req_rd),
    .req_tmask(req_tmask), .req_data(req_data), .req_ready(req_ready),
    .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_rd(wb_rd), .wb_tmask(wb_tmask),
    .wb_data(wb_data), .wb_ready(wb_ready), .perf_conflicts(perf_conflicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the single output slot, the priority pointer and the conflict counter.
  bit          m_valid;
  int          m_wid, m_rd, m_ptr;
  logic [NT-1:0] m_tmask;
  logic [LW-1:0] m_data;
  logic [31:0] m_conf;
  logic [NR-1:0] obs_ready;
  logic [RDW-1:0] prev_rd;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_src(input int i, input bit v, input bit w, input int wid, input int rd,
                         input logic [NT-1:0] tm, input logic [LW-1:0] d);
    logic [31:0] wv, rv;
    wv = wid; rv = rd;
    req_valid[i] = v;
    req_wb[i]    = w;
    req_wid[i*WIDW +: WIDW] = wv[WIDW-1:0];
    req_rd[i*RDW +: RDW]    = rv[RDW-1:0];
    req_tmask[i*NT +: NT]   = tm;
    req_data[i*LW +: LW]    = d;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NR; i++) set_src(i, 1'b0, 1'b0, 0, 0, '0, '0);
  endtask

  // One clock: check combinational req_ready, advance the model across the edge, check wb_*.
  task automatic step();
    logic [NR-1:0] wr, exp_rdy;
    int g, idx, nwr;
    bit can_load;
    int s_wid, s_rd;
    logic [NT-1:0] s_tm;
    logic [LW-1:0] s_d;
    #1;
    nwr = 0;
    for (int i = 0; i < NR; i++) begin
      wr[i] = req_valid[i] && req_wb[i] && (req_rd[i*RDW +: RDW] != 0) && (req_tmask[i*NT +: NT] != 0);
      if (wr[i]) nwr++;
    end
    exp_rdy = '0;
    g = -1;
    if (!reset) begin
      exp_rdy  = req_valid & ~wr;
      can_load = !m_valid || wb_ready;
      for (int k = 0; k < NR; k++) begin
        idx = (m_ptr + k) % NR;
        if (g < 0 && wr[idx]) g = idx;
      end
      if (g >= 0 && can_load) exp_rdy[g] = 1'b1;
      else g = -1;
    end
    obs_ready = req_ready;
    check("req_ready", 128'(req_ready), 128'(exp_rdy));
    s_wid = 0; s_rd = 0; s_tm = '0; s_d = '0;
    if (g >= 0) begin
      s_wid = int'(req_wid[g*WIDW +: WIDW]);
      s_rd  = int'(req_rd[g*RDW +: RDW]);
      s_tm  = req_tmask[g*NT +: NT];
      s_d   = req_data[g*LW +: LW];
    end
    prev_rd = wb_rd;
    @(posedge clk);
    #1;
    if (reset) begin
      m_valid = 0; m_wid = 0; m_rd = 0; m_tmask = '0; m_data = '0; m_ptr = 0; m_conf = 0;
    end else begin
      if (nwr >= 2) m_conf = m_conf + 1;
      if (g >= 0) begin
        m_valid = 1; m_wid = s_wid; m_rd = s_rd; m_tmask = s_tm; m_data = s_d;
        m_ptr = (g + 1) % NR;
      end else if (wb_ready) begin
        m_valid = 0;
      end
    end
    check("wb_valid", 128'(wb_valid), 128'(m_valid));
    check("wb_wid", 128'(wb_wid), 128'(m_wid));
    check("wb_rd", 128'(wb_rd), 128'(m_rd));
    check("wb_tmask", 128'(wb_tmask), 128'(m_tmask));
    check("wb_data", 128'(wb_data), 128'(m_data));
    check("perf_conflicts", 128'(perf_conflicts), 128'(m_conf));
  endtask

  initial begin
    logic [LW-1:0] d;
    logic [31:0] conf0;
    m_valid = 0; m_wid = 0; m_rd = 0; m_tmask = '0; m_data = '0; m_ptr = 0; m_conf = 0;
    clear_all();
    wb_ready = 1'b1;

    // 1: reset with all sources requesting
    reset = 1'b1;
    for (int i = 0; i < NR; i++) set_src(i, 1'b1, 1'b1, i, i + 1, 4'hF, '0);
    step();
    check("t1_rst_ready", 128'(obs_ready), 128'(0));
    step();
    check("t1_rst_valid", 128'(wb_valid), 128'(0));
    check("t1_rst_perf", 128'(perf_conflicts), 128'(0));
    reset = 1'b0;
    clear_all();
    step();
    check("t1_idle_valid", 128'(wb_valid), 128'(0));

    // 2: single writer on source 2
    d = {32'h44, 32'h33, 32'h22, 32'h11};
    set_src(2, 1'b1, 1'b1, 1, 5, 4'b1011, d);
    step();
    check("t2_ready", 128'(obs_ready), 128'(4'b0100));
    check("t2_valid", 128'(wb_valid), 128'(1));
    check("t2_rd", 128'(wb_rd), 128'(5));
    check("t2_wid", 128'(wb_wid), 128'(1));
    check("t2_tmask", 128'(wb_tmask), 128'(4'b1011));
    check("t2_data", 128'(wb_data), 128'(d));
    clear_all();
    step();
    check("t2_drain", 128'(wb_valid), 128'(0));

    // 3: four contending writers from a fresh pointer
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < NR; i++) set_src(i, 1'b1, 1'b1, i, 10 + i, 4'hF, LW'(i * 7 + 1));
    conf0 = perf_conflicts;
    for (int c = 0; c < 5; c++) begin
      step();
      check("t3_grant", 128'(wb_rd), 128'(10 + (c % NR)));
    end
    check("t3_perf", 128'(perf_conflicts - conf0), 128'(5));

    // 4: stalled output; non-writer still retired, writer held off
    clear_all();
    wb_ready = 1'b0;
    set_src(0, 1'b1, 1'b1, 2, 20, 4'b0110, LW'(32'hABCD));
    set_src(1, 1'b1, 1'b0, 0, 9, 4'hF, '0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("t4_stall_ready", 128'(obs_ready), 128'(4'b0010));
      check("t4_stall_rd", 128'(wb_rd), 128'(prev_rd));
    end
    wb_ready = 1'b1;
    step();
    check("t4_release_ready", 128'(obs_ready), 128'(4'b0011));
    check("t4_release_rd", 128'(wb_rd), 128'(20));

    // 5: r0 and empty-mask commits are filtered
    reset = 1'b1; step(); reset = 1'b0;
    clear_all();
    set_src(3, 1'b1, 1'b1, 1, 0, 4'hF, '0);
    step();
    check("t5_r0_ready", 128'(obs_ready), 128'(4'b1000));
    check("t5_r0_valid", 128'(wb_valid), 128'(0));
    set_src(3, 1'b1, 1'b1, 1, 7, 4'h0, '0);
    step();
    check("t5_tm0_ready", 128'(obs_ready), 128'(4'b1000));
    check("t5_tm0_valid", 128'(wb_valid), 128'(0));
    for (int i = 0; i < NR; i++) set_src(i, 1'b1, 1'b1, 0, 30 + i, 4'h1, '0);
    step();
    check("t5_ptr_hold", 128'(obs_ready), 128'(4'b0001));

    // 6: reset discards a stalled entry
    clear_all();
    wb_ready = 1'b0;
    step();
    set_src(0, 1'b1, 1'b1, 3, 40, 4'hF, LW'(32'h5555));
    step();
    clear_all();
    reset = 1'b1;
    step();
    check("t6_rst_valid", 128'(wb_valid), 128'(0));
    check("t6_rst_data", 128'(wb_data), 128'(0));
    reset = 1'b0;
    wb_ready = 1'b1;
    set_src(1, 1'b1, 1'b1, 1, 11, 4'h3, '0);
    set_src(3, 1'b1, 1'b1, 2, 13, 4'h3, '0);
    step();
    check("t6_first_grant", 128'(obs_ready), 128'(4'b0010));

    // Randomized traffic including stalls, filtered commits and occasional reset
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++) begin
        set_src(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 63)),
                4'($urandom_range(0, 4) == 0 ? 0 : $urandom_range(1, 15)),
                {$urandom, $urandom, $urandom, $urandom});
      end
      wb_ready = 1'($urandom_range(0, 3) != 0);
      reset    = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
